// File: rtl/alu_uart_pkg.sv
// +----------------------------------------------------------------------+
// | alu_uart_pkg : shared FSM encoding, frame lengths, flag-byte layout   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

package alu_uart_pkg;

  typedef enum logic [2:0] {
    ST_RX_A    = 3'd0,
    ST_RX_B    = 3'd1,
    ST_RX_OP   = 3'd2,
    ST_EXEC    = 3'd3,
    ST_TX_SEND = 3'd4,
    ST_TX_WAIT = 3'd5
  } state_e;

  localparam int unsigned OPERAND_BYTES     = 4;
  localparam int unsigned RESPONSE_BYTES    = 5;
  localparam int unsigned FLAG_ZERO_BIT     = 0;
  localparam logic [1:0]  LAST_OPERAND_IDX  = 2'(OPERAND_BYTES - 1);
  localparam logic [2:0]  FLAG_BYTE_IDX     = 3'(OPERAND_BYTES);
  localparam logic [2:0]  LAST_RESPONSE_IDX = 3'(RESPONSE_BYTES - 1);

  function automatic logic is_busy_state(input state_e s);
    return (s == ST_EXEC) || (s == ST_TX_SEND) || (s == ST_TX_WAIT);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rx_timeout_counter.sv
// +----------------------------------------------------------------------+
// | rx_timeout_counter : saturating idle-cycle counter for frame resync   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module rx_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_enable,
  input  logic i_clear,
  output logic o_expired
);

  localparam int unsigned NB_COUNT = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [NB_COUNT-1:0] COUNT_LIMIT = NB_COUNT'(TIMEOUT_CYCLES);

  logic [NB_COUNT-1:0] r_count;

  // Saturates at the limit so expiry stays asserted until the FSM clears it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != COUNT_LIMIT)) begin
      r_count <= r_count + NB_COUNT'(1);
    end
  end

  assign o_expired = (r_count == COUNT_LIMIT);

endmodule

`default_nettype wire

// File: rtl/alu_uart_interface.sv
// +----------------------------------------------------------------------+
// | alu_uart_interface : UART byte-frame front end for an external ALU    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module alu_uart_interface
  import alu_uart_pkg::*;
#(
  parameter int unsigned NB_DATA        = 32,
  parameter int unsigned NB_CONTROL     = 6,
  parameter int unsigned NB_BYTE        = 8,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [NB_BYTE-1:0]    i_rx_data,
  input  logic                  i_rx_done,
  input  logic                  i_tx_done,
  output logic [NB_BYTE-1:0]    o_tx_data,
  output logic                  o_tx_start,
  output logic [NB_DATA-1:0]    o_alu_input_A,
  output logic [NB_DATA-1:0]    o_alu_input_B,
  output logic [NB_CONTROL-1:0] o_alu_control_signals,
  input  logic [NB_DATA-1:0]    i_alu_result,
  input  logic                  i_alu_condition_zero,
  output logic                  o_busy
);

  state_e                r_state, w_state_next;
  logic [1:0]            r_idx, w_idx_next;
  logic [2:0]            r_tx_idx, w_tx_idx_next;
  logic [NB_DATA-1:0]    r_a, w_a_next, r_b, w_b_next, r_result, w_result_next;
  logic [NB_CONTROL-1:0] r_ctrl, w_ctrl_next;
  logic                  r_zero, w_zero_next, r_tx_start, w_tx_start_next;
  logic [NB_BYTE-1:0]    r_tx_data, w_tx_data_next, w_flag_byte, w_tx_byte;
  logic [NB_BYTE-1:0]    w_result_bytes [OPERAND_BYTES];
  logic                  w_frame_active, w_rx_state, w_rx_accept, w_expired, w_resync;

  function automatic logic [NB_DATA-1:0] put_byte(input logic [NB_DATA-1:0] word,
                                                  input logic [1:0] idx,
                                                  input logic [NB_BYTE-1:0] b);
    logic [NB_DATA-1:0] v;
    v = word;
    for (int k = 0; k < OPERAND_BYTES; k++) begin
      if (idx == 2'(k)) v[k*NB_BYTE +: NB_BYTE] = b;
    end
    return v;
  endfunction

  assign w_rx_state     = (r_state == ST_RX_A) || (r_state == ST_RX_B) || (r_state == ST_RX_OP);
  assign w_frame_active = w_rx_state && !((r_state == ST_RX_A) && (r_idx == 2'd0));
  assign w_rx_accept    = w_rx_state && i_rx_done;
  // A byte arriving on the expiry cycle wins over the resync.
  assign w_resync       = w_frame_active && w_expired && !i_rx_done;

  rx_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx_timeout_counter (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_enable (w_frame_active),
    .i_clear  (w_rx_accept || !w_frame_active),
    .o_expired(w_expired)
  );

  generate
    for (genvar gi = 0; gi < OPERAND_BYTES; gi++) begin : g_result_bytes
      assign w_result_bytes[gi] = r_result[gi*NB_BYTE +: NB_BYTE];
    end
  endgenerate

  always_comb begin
    w_flag_byte                = '0;
    w_flag_byte[FLAG_ZERO_BIT] = r_zero;
  end

  assign w_tx_byte = (r_tx_idx == FLAG_BYTE_IDX) ? w_flag_byte : w_result_bytes[r_tx_idx[1:0]];

  always_comb begin
    w_state_next    = r_state;
    w_idx_next      = r_idx;
    w_tx_idx_next   = r_tx_idx;
    w_a_next        = r_a;
    w_b_next        = r_b;
    w_ctrl_next     = r_ctrl;
    w_result_next   = r_result;
    w_zero_next     = r_zero;
    w_tx_start_next = 1'b0;
    w_tx_data_next  = r_tx_data;
    case (r_state)
      ST_RX_A, ST_RX_B: begin
        if (i_rx_done) begin
          if (r_state == ST_RX_A) w_a_next = put_byte(r_a, r_idx, i_rx_data);
          else                    w_b_next = put_byte(r_b, r_idx, i_rx_data);
          if (r_idx == LAST_OPERAND_IDX) begin
            w_idx_next   = 2'd0;
            w_state_next = (r_state == ST_RX_A) ? ST_RX_B : ST_RX_OP;
          end else begin
            w_idx_next = r_idx + 2'd1;
          end
        end else if (w_resync) begin
          w_state_next = ST_RX_A;
          w_idx_next   = 2'd0;
        end
      end
      ST_RX_OP: begin
        if (i_rx_done) begin
          w_ctrl_next  = i_rx_data[NB_CONTROL-1:0];
          w_state_next = ST_EXEC;
        end else if (w_resync) begin
          w_state_next = ST_RX_A;
          w_idx_next   = 2'd0;
        end
      end
      ST_EXEC: begin
        w_result_next = i_alu_result;
        w_zero_next   = i_alu_condition_zero;
        w_tx_idx_next = 3'd0;
        w_state_next  = ST_TX_SEND;
      end
      ST_TX_SEND: begin
        w_tx_start_next = 1'b1;
        w_tx_data_next  = w_tx_byte;
        w_state_next    = ST_TX_WAIT;
      end
      ST_TX_WAIT: begin
        if (i_tx_done) begin
          if (r_tx_idx == LAST_RESPONSE_IDX) begin
            w_state_next = ST_RX_A;
            w_idx_next   = 2'd0;
          end else begin
            w_tx_idx_next = r_tx_idx + 3'd1;
            w_state_next  = ST_TX_SEND;
          end
        end
      end
      default: begin
        w_state_next = ST_RX_A;
        w_idx_next   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_RX_A;
      r_idx      <= 2'd0;
      r_tx_idx   <= 3'd0;
      r_a        <= '0;
      r_b        <= '0;
      r_ctrl     <= '0;
      r_result   <= '0;
      r_zero     <= 1'b0;
      r_tx_start <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      r_state    <= w_state_next;
      r_idx      <= w_idx_next;
      r_tx_idx   <= w_tx_idx_next;
      r_a        <= w_a_next;
      r_b        <= w_b_next;
      r_ctrl     <= w_ctrl_next;
      r_result   <= w_result_next;
      r_zero     <= w_zero_next;
      r_tx_start <= w_tx_start_next;
      r_tx_data  <= w_tx_data_next;
    end
  end

  assign o_tx_data             = r_tx_data;
  assign o_tx_start            = r_tx_start;
  assign o_alu_input_A         = r_a;
  assign o_alu_input_B         = r_b;
  assign o_alu_control_signals = r_ctrl;
  assign o_busy                = is_busy_state(r_state);

endmodule

`default_nettype wire

// File: tb/tb_alu_uart_interface.sv
// +----------------------------------------------------------------------+
// | tb_alu_uart_interface : scoreboard bench with behavioural ALU/model  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_alu_uart_interface;

  localparam int NB_DATA    = 32;
  localparam int NB_CONTROL = 6;
  localparam int NB_BYTE    = 8;
  localparam int TIMEOUT    = 40;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NB_BYTE-1:0]    rx_data;
  logic                  rx_done;
  logic                  tx_done;
  logic [NB_BYTE-1:0]    tx_data;
  logic                  tx_start;
  logic [NB_DATA-1:0]    alu_a, alu_b, alu_result;
  logic [NB_CONTROL-1:0] alu_ctrl;
  logic                  alu_zero;
  logic                  busy;

  int checks = 0;
  int errors = 0;
  int tx_seen = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  alu_uart_interface #(
    .NB_DATA(NB_DATA), .NB_CONTROL(NB_CONTROL), .NB_BYTE(NB_BYTE), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx_data(rx_data), .i_rx_done(rx_done),
    .i_tx_done(tx_done), .o_tx_data(tx_data), .o_tx_start(tx_start),
    .o_alu_input_A(alu_a), .o_alu_input_B(alu_b), .o_alu_control_signals(alu_ctrl),
    .i_alu_result(alu_result), .i_alu_condition_zero(alu_zero), .o_busy(busy)
  );

  // MIPS-like function set; unknown codes produce a code-dependent value
  function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [5:0] op);
    case (op)
      6'h20, 6'h21: return a + b;
      6'h22, 6'h23: return a - b;
      6'h24:        return a & b;
      6'h25:        return a | b;
      6'h26:        return a ^ b;
      6'h27:        return ~(a | b);
      6'h2A:        return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'h00:        return b << a[4:0];
      6'h02:        return b >> a[4:0];
      6'h03:        return 32'($signed(b) >>> a[4:0]);
      default:      return a ^ {26'd0, op} ^ 32'hA5A5_0000;
    endcase
  endfunction

  always_comb begin
    alu_result = alu_model(alu_a, alu_b, alu_ctrl);
    alu_zero   = (alu_result == 32'd0);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (tx_start) begin
      tx_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_tx: got byte %02h, none expected", tx_data);
      end else begin
        check("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
      end
      check("busy_during_tx", 32'(busy), 32'd1);
    end
  end

  initial begin
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start) begin
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1 tx_done = 1'b1;
        @(posedge clk);
        #1 tx_done = 1'b0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_data = b;
    rx_done = 1'b1;
    @(posedge clk);
    #1;
    rx_done = 1'b0;
    rx_data = 8'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  // Pushes the expected 5-byte response, then sends A, B (LSB first) and the op byte.
  task automatic send_frame(input logic [31:0] a, input logic [31:0] b, input logic [7:0] opb,
                            input int pause_at, input int pause_len);
    logic [31:0] res;
    logic [7:0]  bytes [9];
    res = alu_model(a, b, 6'(opb & 8'h3F));
    for (int i = 0; i < 4; i++) exp_q.push_back(8'(res >> (8 * i)));
    exp_q.push_back((res == 32'd0) ? 8'h01 : 8'h00);
    for (int i = 0; i < 4; i++) bytes[i] = 8'(a >> (8 * i));
    for (int i = 0; i < 4; i++) bytes[4 + i] = 8'(b >> (8 * i));
    bytes[8] = opb;
    for (int i = 0; i < 9; i++) begin
      if (i == pause_at) idle(pause_len);
      else idle($urandom_range(0, 3));
      send_byte(bytes[i]);
    end
    check("alu_A", alu_a, a);
    check("alu_B", alu_b, b);
    check("alu_ctrl", 32'(alu_ctrl), 32'(opb & 8'h3F));
  endtask

  task automatic wait_idle();
    int n;
    for (n = 0; n < 2000; n++) begin
      @(negedge clk);
      #2;
      if (exp_q.size() == 0 && !busy) break;
    end
    checks++;
    if (n == 2000) begin
      errors++;
      $display("FAIL wait_idle: timed out, %0d bytes outstanding, busy=%0b", exp_q.size(), busy);
      exp_q.delete();
    end
  endtask

  function automatic logic [5:0] pick_op(input int i);
    case (i)
      0: return 6'h20;  1: return 6'h21;  2: return 6'h22;  3: return 6'h23;
      4: return 6'h24;  5: return 6'h25;  6: return 6'h26;  7: return 6'h27;
      8: return 6'h2A;  9: return 6'h00;  10: return 6'h02; 11: return 6'h03;
      default: return 6'h3D;
    endcase
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_start"}, 32'(tx_start), 32'd0);
    check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_A"}, alu_a, 32'd0);
    check({tag, "_B"}, alu_b, 32'd0);
    check({tag, "_ctrl"}, 32'(alu_ctrl), 32'd0);
  endtask

  initial begin
    logic [7:0] opb;
    int base;
    rst_n   = 1'b0;
    rx_done = 1'b0;
    rx_data = 8'h00;
    idle(3);
    #1 check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    send_frame(32'h7FFF_FFFF, 32'h0000_0001, 8'h20, -1, 0);
    wait_idle();
    send_frame(32'h0000_0001, 32'h0000_0001, 8'h22, -1, 0);
    wait_idle();
    send_frame(32'h0000_0000, 32'h0000_0001, 8'hE3, -1, 0);
    wait_idle();

    // Partial frame abandoned by timeout, then a full frame parsed from byte 0.
    send_byte(8'hDE);
    send_byte(8'hAD);
    idle(TIMEOUT + 3);
    send_frame(32'h1234_5678, 32'h0F0F_0F0F, 8'h26, -1, 0);
    wait_idle();

    // Pause just short of the timeout must not resync the frame.
    send_frame(32'hCAFE_0001, 32'h0000_0FF0, 8'h25, 3, TIMEOUT - 4);
    wait_idle();

    // Receive strobes during transmission are dropped.
    send_frame(32'h0000_00F0, 32'h0000_0100, 8'h21, -1, 0);
    for (int i = 0; i < 3; i++) begin
      #2 check("busy_before_drop", 32'(busy), 32'd1);
      send_byte(8'($urandom));
    end
    wait_idle();
    send_frame(32'h8000_0000, 32'h0000_0004, 8'h03, -1, 0);
    wait_idle();

    // Reset in the middle of the response.
    send_frame(32'h0102_0304, 32'h1111_1111, 8'h20, -1, 0);
    base = tx_seen;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      #2;
      if (tx_seen >= base + 2) break;
    end
    check("second_tx_reached", 32'(tx_seen >= base + 2), 32'd1);
    rst_n = 1'b0;
    exp_q.delete();
    #1 check_reset_outputs("midtx_reset");
    idle(3);
    @(negedge clk);
    rst_n = 1'b1;
    idle(10);
    send_frame(32'h0000_0005, 32'h0000_0003, 8'h2A, -1, 0);
    wait_idle();

    for (int f = 0; f < 20; f++) begin
      opb = {2'($urandom_range(0, 3)), pick_op(int'($urandom_range(0, 12)))};
      send_frame($urandom, ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom, opb, -1, 0);
      wait_idle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/alu_uart_interface.md
ALU_UART_INTERFACE -- requirements
Module: alu_uart_interface

Interface
REQ-001 SHALL have parameter NB_DATA, default 32, meaning ALU operand and result width.
REQ-002 SHALL have parameter NB_CONTROL, default 6, meaning ALU control-code width.
REQ-003 SHALL have parameter NB_BYTE, default 8, meaning UART byte width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 100000, meaning the inter-byte receive timeout in clocks.
REQ-005 SHALL have port i_clk  input  1  system clock; single clock domain; all state updates on its rising edge.
REQ-006 SHALL have port i_rst_n  input  1  reset; asynchronous assert, active-low.
REQ-007 SHALL have port i_rx_data  input  NB_BYTE  received byte; valid only while i_rx_done=1.
REQ-008 SHALL have port i_rx_done  input  1  one-cycle strobe; new byte available.
REQ-009 SHALL have port i_tx_done  input  1  one-cycle strobe; transmitter finished the current byte.
REQ-010 SHALL have port o_tx_data  output  NB_BYTE  byte to transmit.
REQ-011 SHALL have port o_tx_start  output  1  one-cycle strobe; transmit o_tx_data.
REQ-012 SHALL have port o_alu_input_A  output  NB_DATA  operand A to ALU.
REQ-013 SHALL have port o_alu_input_B  output  NB_DATA  operand B to ALU.
REQ-014 SHALL have port o_alu_control_signals  output  NB_CONTROL  ALU function code.
REQ-015 SHALL have port i_alu_result  input  NB_DATA  combinational ALU result.
REQ-016 SHALL have port i_alu_condition_zero  input  1  ALU zero flag.
REQ-017 SHALL have port o_busy  output  1  high in states EXEC, TX_SEND, TX_WAIT.

Function
REQ-018 SHALL implement states RX_A, RX_B, RX_OP, EXEC, TX_SEND, TX_WAIT, with a 2-bit byte index.
REQ-019 SHALL, in RX_A/RX_B, load one byte of A/B per i_rx_done, LSB first; after byte index 3, advance to the next state and clear the index.
REQ-020 SHALL, in RX_OP, load o_alu_control_signals from i_rx_data[NB_CONTROL-1:0] on i_rx_done, ignore the upper bits, and advance to EXEC.
REQ-021 SHALL hold operand and control registers stable from EXEC through the end of TX_WAIT.
REQ-022 SHALL, in EXEC (exactly one cycle), register i_alu_result and i_alu_condition_zero, then go to TX_SEND.
REQ-023 SHALL send a 5-byte response: result bytes 0..3 LSB first, then {7'b0, zero}.
REQ-024 SHALL, in TX_SEND, drive o_tx_data, pulse o_tx_start for exactly one cycle, and go to TX_WAIT.
REQ-025 SHALL, in TX_WAIT on i_tx_done, return to TX_SEND for the next byte, or to RX_A after byte 4.
REQ-026 SHALL latch o_tx_start and o_tx_data (registered outputs); the first o_tx_start is asserted 2 cycles after the edge that accepted the op byte.
REQ-027 SHALL ignore and drop i_rx_done while in EXEC, TX_SEND or TX_WAIT.
REQ-028 SHALL ignore i_tx_done outside TX_WAIT.
REQ-029 SHALL, in RX_A/RX_B/RX_OP with at least one frame byte received, count idle cycles; when the count reaches TIMEOUT_CYCLES, go to RX_A with index 0, leaving operand registers unchanged.
REQ-030 SHALL, when i_rx_done and timeout expiry occur in the same cycle, accept the byte and clear the counter; no resync occurs.
REQ-031 SHALL keep the timeout counter at 0 in RX_A with index 0, and clear it on every accepted byte.
REQ-032 SHALL treat all control codes as pass-through; unknown codes are forwarded, and the ALU response is returned unmodified.

Reset
REQ-033 SHALL, on i_rst_n=0 at any time (including mid-frame or mid-TX), immediately enter RX_A with index 0 and set the timeout counter to 0.
REQ-034 SHALL drive o_tx_start=0, o_tx_data=0, o_alu_input_A=0, o_alu_input_B=0, o_alu_control_signals=0, o_busy=0 while in reset.
REQ-035 SHALL clear the result/zero registers during reset, and start a fresh frame on deassertion.

Structure
REQ-036 SHALL keep state encoding, frame lengths (4 operand bytes, 5 response bytes) and the flag-byte layout in shared package alu_uart_pkg.
REQ-037 SHALL implement the inter-byte timeout as sub-module rx_timeout_counter (inputs: enable, clear; output: expired); everything else SHALL be in one FSM.

Verification
REQ-038 SHALL verify: A=FF FF FF 7F, B=01 00 00 00, op=0x20, ALU model → TX bytes 00 00 00 80, then 00.
REQ-039 SHALL verify: A=01000000h-style bytes 01 00 00 00 (both operands), op=0x22 → TX 00 00 00 00 01; zero flag byte=01.
REQ-040 SHALL verify: op byte 0xE3 → o_alu_control_signals=0x23; 0x00000000-0x00000001 → TX FF FF FF FF 00.
REQ-041 SHALL verify: 2 bytes sent, idle TIMEOUT_CYCLES, then a full valid frame → correct response, no stale byte.
REQ-042 SHALL verify: i_rx_done pulses during TX_WAIT → dropped; the next frame is parsed from byte 0.
REQ-043 SHALL verify: reset asserted after 2nd TX byte → o_tx_start=0 immediately, no further TX, a new frame works.
